// File: rtl/ntsc_capture_pack_pkg.sv
// Shared widths, frame geometry, FSM states and the FIFO entry layout for the
// NTSC capture write path.
package ntsc_capture_pack_pkg;

  localparam int unsigned LOG_MEM       = 36;
  localparam int unsigned LOG_HCOUNT    = 10;
  localparam int unsigned LOG_VCOUNT    = 10;
  localparam int unsigned PIX_W         = 18;
  localparam int unsigned NTSC_H_ACTIVE = 640;
  localparam int unsigned NTSC_V_ACTIVE = 480;
  localparam int unsigned ENTRY_W       = LOG_MEM + LOG_HCOUNT + LOG_VCOUNT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [LOG_MEM-1:0]    pixel;
    logic [LOG_HCOUNT-1:0] hcount;
    logic [LOG_VCOUNT-1:0] vcount;
  } word_t;

  function automatic logic [LOG_HCOUNT-1:0] sat_inc_h(input logic [LOG_HCOUNT-1:0] v);
    return (&v) ? v : v + LOG_HCOUNT'(1);
  endfunction

  function automatic logic [LOG_VCOUNT-1:0] sat_inc_v(input logic [LOG_VCOUNT-1:0] v);
    return (&v) ? v : v + LOG_VCOUNT'(1);
  endfunction

endpackage

// File: rtl/ntsc_capture_pack_if.sv
// Memory-side write handshake: head word plus flag/done.
interface ntsc_capture_pack_if;
  import ntsc_capture_pack_pkg::*;

  logic                  ntsc_flag;
  logic [LOG_MEM-1:0]    ntsc_pixel;
  logic [LOG_HCOUNT-1:0] ntsc_hcount;
  logic [LOG_VCOUNT-1:0] ntsc_vcount;
  logic                  done_ntsc;

  modport master (
    output ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount,
    input  done_ntsc
  );

  modport slave (
    input  ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount,
    output done_ntsc
  );
endinterface

// File: rtl/ntsc_capture_pack_fifo.sv
// Single-clock first-word-fall-through FIFO for packed pixel-pair entries.
// Head reads as zero while empty; push+pop is accepted even when full.
module capture_word_fifo #(
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [LOG_DEPTH:0] FULL_CNT = DEPTH[LOG_DEPTH:0];

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ntsc_capture_pack.sv
// Camera-pixel capture: tracks frame position, packs even/odd pixel pairs into
// memory words and queues them toward the memory write handshake.
module ntsc_capture_pack
  import ntsc_capture_pack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOG_DEPTH  = 4,
  parameter int unsigned H_ACTIVE   = NTSC_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = NTSC_V_ACTIVE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_flag,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_sof,
  input  logic               pix_eol,
  ntsc_capture_pack_if.master mem,
  output logic               overflow,
  capturing
);

  localparam logic [LOG_HCOUNT-1:0] H_LIM = H_ACTIVE[LOG_HCOUNT-1:0];
  localparam logic [LOG_VCOUNT-1:0] V_LIM = V_ACTIVE[LOG_VCOUNT-1:0];

  cap_state_t            state_q, state_d;
  logic [LOG_HCOUNT-1:0] hcnt_q, hcnt_d;
  logic [LOG_VCOUNT-1:0] vcnt_q, vcnt_d;
  logic [PIX_W-1:0]      lo_q, lo_d;
  logic                  half_q, half_d;
  logic                  ovf_q, ovf_d;

  logic                  sof_acc, pix_acc, eol_act;
  logic [LOG_HCOUNT-1:0] pix_h;
  logic [LOG_VCOUNT-1:0] pix_v;
  logic                  push_req;
  word_t                 push_w, head_w;
  logic                  fifo_full, fifo_empty;

  // A sof pixel is taken in ARMED or CAPTURE and restarts the frame position;
  // its position is forced to (0,0) in the same cycle it is accepted.
  assign sof_acc  = pix_valid & pix_sof & ((state_q == ARMED) | (state_q == CAPTURE));
  assign pix_acc  = pix_valid & ((state_q == CAPTURE) | sof_acc);
  assign eol_act  = pix_eol & ((state_q == CAPTURE) | sof_acc);
  assign pix_h    = sof_acc ? '0 : hcnt_q;
  assign pix_v    = sof_acc ? '0 : vcnt_q;
  assign push_req = pix_acc & pix_h[0] & half_q & (pix_h < H_LIM) & (pix_v < V_LIM);

  // Odd pixel completes the pair; word is addressed by its even partner.
  always_comb begin
    push_w        = '0;
    push_w.pixel  = {pix_data, lo_q};
    push_w.hcount = {pix_h[LOG_HCOUNT-1:1], 1'b0};
    push_w.vcount = pix_v;
  end

  // Capture FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_flag) state_d = ARMED;
      ARMED:   if (pix_valid && pix_sof) state_d = CAPTURE;
      CAPTURE: if (frame_flag) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Position counters, half-pair latch and sticky overflow. The accepted pixel
  // is applied before a same-cycle eol, which then resets the line position.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    lo_d   = lo_q;
    half_d = half_q;
    ovf_d  = ovf_q;
    if (sof_acc) ovf_d = 1'b0;
    if (pix_acc) begin
      hcnt_d = sat_inc_h(pix_h);
      vcnt_d = pix_v;
      if (!pix_h[0]) begin
        lo_d   = pix_data;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
      end
    end
    if (eol_act) begin
      hcnt_d = '0;
      vcnt_d = sat_inc_v(pix_v);
      half_d = 1'b0;
    end
    if (push_req && fifo_full && !mem.done_ntsc) ovf_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      lo_q    <= '0;
      half_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      lo_q    <= lo_d;
      half_q  <= half_d;
      ovf_q   <= ovf_d;
    end
  end

  capture_word_fifo #(
    .WIDTH    (ENTRY_W),
    .DEPTH    (FIFO_DEPTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push_req),
    .push_data_i(push_w),
    .pop_i      (mem.done_ntsc),
    .head_o     (head_w),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mem.ntsc_flag   = ~fifo_empty;
  assign mem.ntsc_pixel  = head_w.pixel;
  assign mem.ntsc_hcount = head_w.hcount;
  assign mem.ntsc_vcount = head_w.vcount;
  assign overflow        = ovf_q;
  assign capturing       = (state_q == CAPTURE);

endmodule

// File: tb/tb_ntsc_capture_pack.sv
module tb_ntsc_capture_pack;
  import ntsc_capture_pack_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_flag = 1'b0;
  logic        pix_valid = 1'b0;
  logic [17:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_eol = 1'b0;
  logic        overflow, capturing;

  ntsc_capture_pack_if u_if();

  ntsc_capture_pack #(
    .FIFO_DEPTH(16),
    .LOG_DEPTH (4),
    .H_ACTIVE  (640),
    .V_ACTIVE  (480)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_flag(frame_flag),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .mem       (u_if),
    .overflow  (overflow),
    .capturing (capturing)
  );

  always #5 clock = ~clock;

  int    tests_run = 0;
  int    tests_failed = 0;
  int    n_writes = 0;
  word_t exp_q[$];
  word_t mon_e;

  // reference model state
  int          m_st = 0;
  int          mh = 0;
  int          mv = 0;
  bit          mhalf = 0;
  logic [17:0] mlo = '0;
  bit          movf = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted write is compared with the oldest expectation
  always @(negedge clock) begin
    if (u_if.ntsc_flag && u_if.done_ntsc) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_pixel", u_if.ntsc_pixel, mon_e.pixel);
        check("wr_hcount", u_if.ntsc_hcount, mon_e.hcount);
        check("wr_vcount", u_if.ntsc_vcount, mon_e.vcount);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; mh = 0; mv = 0; mhalf = 0; mlo = '0; movf = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [17:0] d, input bit sof, input bit eol);
    bit    acc;
    word_t w;
    acc = 0;
    if (v && sof && m_st != 0) begin
      m_st = 2; mh = 0; mv = 0; mhalf = 0; movf = 0; acc = 1;
    end else if (v && m_st == 2) begin
      acc = 1;
    end
    if (acc) begin
      if (mh % 2 == 0) begin
        mlo = d;
        mhalf = 1;
      end else begin
        if (mhalf && mh < 640 && mv < 480) begin
          w.pixel  = {d, mlo};
          w.hcount = 10'(mh - 1);
          w.vcount = 10'(mv);
          if (exp_q.size() >= 16 && !u_if.done_ntsc) movf = 1;
          else exp_q.push_back(w);
        end
        mhalf = 0;
      end
      if (mh < 1023) mh++;
    end
    if (eol && m_st == 2) begin
      mh = 0;
      if (mv < 1023) mv++;
      mhalf = 0;
    end
  endtask

  task automatic drive(input bit v, input logic [17:0] d, input bit sof, input bit eol);
    model_step(v, d, sof, eol);
    pix_valid = v; pix_data = d; pix_sof = sof; pix_eol = eol;
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
  endtask

  task automatic frame();
    if (m_st == 0 || m_st == 2) m_st = 1;
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_flag"}, u_if.ntsc_flag, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flag"}, u_if.ntsc_flag, 1'b0);
    check({tag, "_pixel"}, u_if.ntsc_pixel, '0);
    check({tag, "_hcount"}, u_if.ntsc_hcount, '0);
    check({tag, "_vcount"}, u_if.ntsc_vcount, '0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_capt"}, capturing, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    u_if.done_ntsc = 1'b0;
    tick();
    do_reset();
    check_idle_outputs("reset");

    // 1: first two pairs, latency and packing order
    frame();
    drive(1, 18'h00001, 1, 0);
    check("t1_flag_early", u_if.ntsc_flag, 1'b0);
    check("t1_capt", capturing, 1'b1);
    drive(1, 18'h00002, 0, 0);
    check("t1_flag_lat", u_if.ntsc_flag, 1'b1);
    check("t1_head_pix", u_if.ntsc_pixel, 36'h000080001);
    check("t1_head_hc", u_if.ntsc_hcount, 10'd0);
    drive(1, 18'h00003, 0, 0);
    drive(1, 18'h00004, 0, 0);
    check("t1_head_hold", u_if.ntsc_pixel, 36'h000080001);
    w0 = n_writes;
    u_if.done_ntsc = 1'b1;
    wait_drain("t1", 10);
    check("t1_writes", n_writes - w0, 2);

    // 2: full line with overrun pixels, then start of second line
    w0 = n_writes;
    drive(1, 18'($urandom), 1, 0);
    for (int h = 1; h < 650; h++) drive(1, 18'($urandom), 0, 0);
    drive(0, '0, 0, 1);
    for (int h = 0; h < 16; h++) drive(1, 18'($urandom), 0, 0);
    drive(0, '0, 0, 1);
    wait_drain("t2", 50);
    check("t2_writes", n_writes - w0, 328);
    u_if.done_ntsc = 1'b0;

    // 3: fill past capacity with no memory service
    w0 = n_writes;
    drive(1, 18'($urandom), 1, 0);
    for (int h = 1; h < 34; h++) drive(1, 18'($urandom), 0, 0);
    check("t3_ovf", overflow, 1'b1);
    check("t3_ovf_model", overflow, movf);
    check("t3_flag", u_if.ntsc_flag, 1'b1);
    repeat (3) tick();
    check("t3_head_pix", u_if.ntsc_pixel, exp_q[0].pixel);
    check("t3_head_hc", u_if.ntsc_hcount, 10'd0);
    u_if.done_ntsc = 1'b1;
    wait_drain("t3", 40);
    check("t3_writes", n_writes - w0, 16);

    // 4: eol after odd pixel count drops the pending half
    w0 = n_writes;
    drive(1, 18'h11111, 1, 0);
    check("t4_ovf_clr", overflow, 1'b0);
    drive(1, 18'h22222, 0, 0);
    drive(1, 18'h33333, 0, 0);
    drive(0, '0, 0, 1);
    drive(1, 18'h04444, 0, 0);
    drive(1, 18'h05555, 0, 0);
    wait_drain("t4", 10);
    check("t4_writes", n_writes - w0, 2);
    u_if.done_ntsc = 1'b0;

    // 5: pixels before arming / before sof are ignored
    do_reset();
    w0 = n_writes;
    drive(1, 18'h0AAAA, 1, 0);
    for (int h = 0; h < 4; h++) drive(1, 18'($urandom), 0, 0);
    check("t5_idle_capt", capturing, 1'b0);
    check("t5_idle_flag", u_if.ntsc_flag, 1'b0);
    frame();
    for (int h = 0; h < 6; h++) drive(1, 18'($urandom), 0, 0);
    check("t5_armed_capt", capturing, 1'b0);
    check("t5_armed_flag", u_if.ntsc_flag, 1'b0);
    check("t5_writes", n_writes - w0, 0);

    // 6: reset with words queued and a half-pair pending
    drive(1, 18'($urandom), 1, 0);
    for (int h = 1; h < 11; h++) drive(1, 18'($urandom), 0, 0);
    check("t6_flag_pre", u_if.ntsc_flag, 1'b1);
    do_reset();
    check_idle_outputs("t6_rst");
    w0 = n_writes;
    u_if.done_ntsc = 1'b1;
    frame();
    drive(1, 18'h00005, 1, 0);
    drive(1, 18'h00006, 0, 0);
    drive(1, 18'h00007, 0, 0);
    drive(1, 18'h00008, 0, 0);
    wait_drain("t6", 10);
    check("t6_writes", n_writes - w0, 2);
    u_if.done_ntsc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
